cdb_broadcast: RTL and testbench

- Complete-stage transmitter for the common data bus (CDB).
- Collects finished results from the functional units (FUs), one holding slot per FU, and broadcasts one destination physical-register tag per cycle.
- Drives CDB_T and complete_en, which the reservation station, map table and ROB consume to wake up waiting operands.
- Sits between the FU outputs and every CDB listener.

---
 rtl/cdb_broadcast_pkg.sv | 25 ++
 rtl/cdb_broadcast_arbiter.sv | 53 +++++
 rtl/cdb_broadcast.sv | 110 +++++++++++
 tb/tb_cdb_broadcast.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcast_pkg.sv
// Shared types for the CDB complete stage: holding slot, outgoing CDB packet,
// slot reset value and the pointer-width helper used by the arbiter and the top.
package cdb_broadcast_pkg;

  localparam int CDB_NUM_FU  = 5;
  localparam int CDB_T_IDX_W = 6;

  typedef struct packed {
    logic                   valid;
    logic [CDB_T_IDX_W-1:0] T_idx;
  } CDB_SLOT_t;

  // Same layout the RS, map table and ROB listeners decode.
  typedef struct packed {
    logic [CDB_T_IDX_W-1:0] CDB_T;
    logic                   complete_en;
  } CDB_PACKET_OUT;

  localparam CDB_SLOT_t CDB_SLOT_RESET = '{valid: 1'b0, T_idx: '0};

  function automatic int cdb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_broadcast_arbiter.sv
// Combinational slot picker for the CDB. CDB_ROUND_ROBIN_EN selects round-robin
// starting at rr_ptr_i; otherwise the lowest-index request wins.
module cdb_arbiter
  import cdb_broadcast_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  localparam int PTR_W = cdb_ptr_w(NUM_FU)
) (
  input  logic [NUM_FU-1:0] req_i,
`ifdef CDB_ROUND_ROBIN_EN
  input  logic [PTR_W-1:0]  rr_ptr_i,
  output logic [PTR_W-1:0]  win_idx_o,
`endif
  output logic [NUM_FU-1:0] grant_o
);

  logic found;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o   = '0;
    win_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        win_idx_o    = idx;
      end
    end
  end
`else
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_broadcast.sv
// CDB complete-stage transmitter: one holding slot per FU, one tag broadcast per cycle.
// Arbitration policy lives in cdb_arbiter and is chosen by CDB_ROUND_ROBIN_EN.
module cdb_broadcast
  import cdb_broadcast_pkg::*;
#(
  parameter int NUM_FU  = CDB_NUM_FU,
  parameter int T_IDX_W = CDB_T_IDX_W   // must equal CDB_T_IDX_W; slots use the package struct
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU*T_IDX_W-1:0] fu_T_idx,
  output logic [NUM_FU-1:0]         fu_ready,
  output logic [T_IDX_W-1:0]        CDB_T,
  output logic                      complete_en,
  output logic [NUM_FU-1:0]         cdb_grant
);

  localparam int PTR_W = cdb_ptr_w(NUM_FU);

  CDB_SLOT_t     slot_q [NUM_FU];
  CDB_SLOT_t     slot_d [NUM_FU];
  CDB_PACKET_OUT pkt;

  logic [NUM_FU-1:0]  req;
  logic [NUM_FU-1:0]  grant_raw;
  logic [NUM_FU-1:0]  accept;
  logic [T_IDX_W-1:0] t_mux;
  logic               active;

  // Reset is folded in so fu_ready drops with reset, not just at the next edge.
  assign active = reset & en & ~flush;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) req[i] = slot_q[i].valid;
  end

`ifdef CDB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_q, rr_d, win_idx;

  cdb_arbiter #(.NUM_FU(NUM_FU)) u_arb (
    .req_i     (req),
    .rr_ptr_i  (rr_q),
    .win_idx_o (win_idx),
    .grant_o   (grant_raw)
  );
`else
  cdb_arbiter #(.NUM_FU(NUM_FU)) u_arb (
    .req_i   (req),
    .grant_o (grant_raw)
  );
`endif

  always_comb begin
    t_mux = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant_raw[i]) t_mux = t_mux | slot_q[i].T_idx;
    end
    pkt.complete_en = active & (|grant_raw);
    pkt.CDB_T       = pkt.complete_en ? t_mux : '0;
  end

  assign complete_en = pkt.complete_en;
  assign CDB_T       = pkt.CDB_T;
  assign cdb_grant   = active ? grant_raw : '0;
  assign fu_ready    = {NUM_FU{active}} & (~req | cdb_grant);
  assign accept      = fu_done & fu_ready;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) slot_d[i] = slot_q[i];
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) slot_d[i].valid = 1'b0;
    end else begin
      // A granted slot that accepts in the same cycle is simply reloaded.
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          slot_d[i].valid = 1'b1;
          slot_d[i].T_idx = fu_T_idx[i*T_IDX_W +: T_IDX_W];
        end else if (cdb_grant[i]) begin
          slot_d[i].valid = 1'b0;
        end
      end
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  always_comb begin
    rr_d = rr_q;
    if (pkt.complete_en) begin
      rr_d = (win_idx == PTR_W'(NUM_FU-1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) slot_q[i] <= CDB_SLOT_RESET;
    end else begin
      for (int i = 0; i < NUM_FU; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed bench for cdb_broadcast (NUM_FU=5, T_IDX_W=6); expectations follow the
// arbitration policy selected by CDB_ROUND_ROBIN_EN.
module tb_cdb_broadcast;

  localparam int NFU = 5;
  localparam int TW  = 6;

`ifdef CDB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset, en, flush;
  logic [NFU-1:0]  fu_done;
  logic [NFU*TW-1:0] fu_T_idx;
  logic [NFU-1:0]  fu_ready;
  logic [TW-1:0]   CDB_T;
  logic            complete_en;
  logic [NFU-1:0]  cdb_grant;

  int errors = 0;
  int checks = 0;

  cdb_broadcast #(.NUM_FU(NFU), .T_IDX_W(TW)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .flush       (flush),
    .fu_done     (fu_done),
    .fu_T_idx    (fu_T_idx),
    .fu_ready    (fu_ready),
    .CDB_T       (CDB_T),
    .complete_en (complete_en),
    .cdb_grant   (cdb_grant)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_t(input int i, input int t);
    fu_T_idx[i*TW +: TW] = TW'(t);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; flush = 1'b0; fu_done = '0; fu_T_idx = '0;
    #1;
    check("rst_ready", 32'(fu_ready), 0);
    check("rst_ce", 32'(complete_en), 0);
    check("rst_t", 32'(CDB_T), 0);
    check("rst_grant", 32'(cdb_grant), 0);
    #1 reset = 1'b1;
    #1;
    check("idle_ready", 32'(fu_ready), 32'h1f);
    check("idle_ce", 32'(complete_en), 0);

    // single completion
    fu_done = 5'b00100; set_t(2, 17);
    #1;
    check("single_ready2", 32'(fu_ready[2]), 1);
    step(); fu_done = '0; #1;
    check("single_ce", 32'(complete_en), 1);
    check("single_t", 32'(CDB_T), 17);
    check("single_grant", 32'(cdb_grant), 32'b00100);
    step(); #1;
    check("single_done", 32'(complete_en), 0);

    // reset pulse between edges so rr_ptr starts at 0
    reset = 1'b0; #1 reset = 1'b1; #1;

    // full contention
    fu_done = '1;
    for (int i = 0; i < NFU; i++) set_t(i, 10 + i);
    #1;
    check("full_accept", 32'(fu_ready), 32'h1f);
    step(); fu_done = '0; #1;
    for (int k = 0; k < NFU; k++) begin
      check($sformatf("full_t%0d", k), 32'(CDB_T), 10 + k);
      check($sformatf("full_grant%0d", k), 32'(cdb_grant), 1 << k);
      check($sformatf("full_ready%0d", k), 32'(fu_ready), (1 << (k + 1)) - 1);
      step(); #1;
    end
    check("full_drained", 32'(complete_en), 0);

    // fairness: FU0 and FU3 request continuously
    fu_done = 5'b01001; set_t(0, 1); set_t(3, 4);
    #1; step(); #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fair_ce%0d", k), 32'(complete_en), 1);
      check($sformatf("fair_t%0d", k), 32'(CDB_T), (RR && (k % 2 == 1)) ? 4 : 1);
      step(); #1;
    end
    fu_done = '0; flush = 1'b1; #1;
    check("fair_flush_ce", 32'(complete_en), 0);
    check("fair_flush_ready", 32'(fu_ready), 0);
    step(); flush = 1'b0; #1;
    check("fair_post_flush", 32'(complete_en), 0);

    // back-to-back on FU1
    fu_done = 5'b00010; set_t(1, 20); #1;
    check("b2b_ready_a", 32'(fu_ready[1]), 1);
    step(); set_t(1, 21); #1;
    check("b2b_ce_a", 32'(complete_en), 1);
    check("b2b_t_a", 32'(CDB_T), 20);
    check("b2b_ready_b", 32'(fu_ready[1]), 1);
    step(); fu_done = '0; #1;
    check("b2b_ce_b", 32'(complete_en), 1);
    check("b2b_t_b", 32'(CDB_T), 21);
    step(); #1;
    check("b2b_idle", 32'(complete_en), 0);

    // stall then flush with slots 0 and 4 held
    fu_done = 5'b10001; set_t(0, 30); set_t(4, 34); #1;
    step(); fu_done = '0; en = 1'b0; #1;
    check("stall_ce0", 32'(complete_en), 0);
    check("stall_ready0", 32'(fu_ready), 0);
    check("stall_t0", 32'(CDB_T), 0);
    step(); #1;
    check("stall_ce1", 32'(complete_en), 0);
    check("stall_grant1", 32'(cdb_grant), 0);
    step(); en = 1'b1; flush = 1'b1; #1;
    check("flush_ce", 32'(complete_en), 0);
    check("flush_ready", 32'(fu_ready), 0);
    step(); flush = 1'b0; #1;
    check("post_flush_ce", 32'(complete_en), 0);
    check("post_flush_grant", 32'(cdb_grant), 0);
    step(); #1;
    check("post_flush_ce2", 32'(complete_en), 0);

    // async reset mid-broadcast
    fu_done = 5'b00100; set_t(2, 9); #1;
    step(); fu_done = '0; #1;
    check("arst_pre_ce", 32'(complete_en), 1);
    check("arst_pre_t", 32'(CDB_T), 9);
    #1 reset = 1'b0;
    #1;
    check("arst_ce", 32'(complete_en), 0);
    check("arst_t", 32'(CDB_T), 0);
    check("arst_ready", 32'(fu_ready), 0);
    check("arst_grant", 32'(cdb_grant), 0);
    #1 reset = 1'b1;
    step(); #1;
    check("arst_slots_empty", 32'(complete_en), 0);
    fu_done = '1;
    for (int i = 0; i < NFU; i++) set_t(i, 40 + i);
    #1; step(); fu_done = '0; #1;
    check("arst_ptr_t", 32'(CDB_T), 40);
    check("arst_ptr_grant", 32'(cdb_grant), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
